// File: rtl/dvi_pll_pkg.sv
// dvi_pll_pkg: shared types, rPLL mode table and dynamic-port encoding
// for the DVI PLL controller.
package dvi_pll_pkg;

   typedef enum logic [2:0] {
      ST_RESET_HOLD = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_STABLE     = 3'd2,
      ST_RUN        = 3'd3,
      ST_FAIL       = 3'd4
   } pll_state_t;

   typedef struct packed {
      logic [5:0] idiv;
      logic [5:0] fbdiv;
      logic [5:0] odiv;
   } pll_mode_t;

   localparam logic [1:0] MODE_DEF = 2'd0;

   // CLKOUT = 27 * (FBDIV_SEL + 1) / (IDIV_SEL + 1); index 0 is the LSB entry
   localparam pll_mode_t [3:0] MODE_TABLE = {
      pll_mode_t'{idiv: 6'd2, fbdiv: 6'd13, odiv: 6'd4},
      pll_mode_t'{idiv: 6'd0, fbdiv: 6'd4,  odiv: 6'd4},
      pll_mode_t'{idiv: 6'd3, fbdiv: 6'd54, odiv: 6'd2},
      pll_mode_t'{idiv: 6'd4, fbdiv: 6'd36, odiv: 6'd4}
   };

   // rPLL dynamic select ports take the one's complement of the _SEL value
   function automatic logic [5:0] pll_dyn_enc(input logic [5:0] sel);
      return ~sel;
   endfunction

endpackage

// File: rtl/dvi_pll_ctrl_lock_sync.sv
// dvi_pll_lock_sync: two-flop synchronizer bringing the asynchronous
// PLL LOCK into the reference clock domain.
module dvi_pll_lock_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // two-stage capture of the asynchronous lock level
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/dvi_pll_ctrl.sv
// dvi_pll_ctrl: rPLL reset/lock sequencer and pixel-pipeline reset release.
// Define DVI_PLL_CTRL_DYN_EN to allow runtime video-mode (divider) changes.
module dvi_pll_ctrl #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRY     = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode_sel,
   input  logic       mode_req,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic [5:0] idsel,
   output logic [5:0] fbdsel,
   output logic [5:0] odsel,
   output logic       pix_rst,
   output logic       locked,
   output logic       busy,
   output logic       fail,
   output logic [1:0] mode_cur
);

   import dvi_pll_pkg::*;

   localparam int CMAX_A = (RST_CYCLES > STABLE_CYCLES) ?
                           RST_CYCLES : STABLE_CYCLES;
   localparam int CMAX   = (LOCK_TIMEOUT > CMAX_A) ? LOCK_TIMEOUT : CMAX_A;
   localparam int CW     = $clog2(CMAX + 1);
   localparam int RW     = $clog2(MAX_RETRY + 1);

   localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RTY_LAST = RW'(MAX_RETRY - 1);

`ifdef DVI_PLL_CTRL_DYN_EN
   localparam bit DYN = 1'b1;
`else
   localparam bit DYN = 1'b0;
`endif

   pll_state_t      state;
   pll_state_t      state_d;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_d;
   logic [RW-1:0]   retry;
   logic [RW-1:0]   retry_d;
   logic            fail_d;
   logic            load;
   logic            lock_s;
   logic [1:0]      mode_nxt;
   pll_mode_t       mode_ent;

   dvi_pll_lock_sync u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_lock),
      .q   (lock_s)
   );

`ifdef DVI_PLL_CTRL_DYN_EN
   assign mode_nxt = mode_sel;
`else
   logic unused_sel;
   assign mode_nxt   = MODE_DEF;
   assign unused_sel = ^mode_sel;
`endif

   assign mode_ent = MODE_TABLE[mode_nxt];

   // sequencing decisions: hold, lock wait with timeout, stability count
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      retry_d = retry;
      fail_d  = fail;
      load    = 1'b0;
      unique case (state)
         ST_RESET_HOLD: begin
            if (cnt == RST_LAST) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               // this high sample is the first of the stable run
               state_d = ST_STABLE;
               cnt_d   = CW'(1);
            end else if (cnt == TO_LAST) begin
               cnt_d = '0;
               if (retry == RTY_LAST) begin
                  state_d = ST_FAIL;
                  retry_d = RW'(MAX_RETRY);
                  fail_d  = 1'b1;
               end else begin
                  state_d = ST_RESET_HOLD;
                  retry_d = retry + RW'(1);
               end
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         ST_STABLE: begin
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt == STB_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               retry_d = '0;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         ST_RUN: begin
            retry_d = '0;
            if (DYN && mode_req) begin
               state_d = ST_RESET_HOLD;
               cnt_d   = '0;
               load    = 1'b1;
            end else if (!lock_s) begin
               state_d = ST_RESET_HOLD;
               cnt_d   = '0;
            end
         end
         ST_FAIL: begin
            if (mode_req) begin
               state_d = ST_RESET_HOLD;
               cnt_d   = '0;
               retry_d = '0;
               fail_d  = 1'b0;
               load    = 1'b1;
            end
         end
         default: begin
            state_d = ST_RESET_HOLD;
            cnt_d   = '0;
         end
      endcase
   end

   // state, timer and retry registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RESET_HOLD;
         cnt   <= '0;
         retry <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         retry <= retry_d;
      end
   end

   // status outputs registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         pll_reset <= 1'b1;
         pix_rst   <= 1'b1;
         locked    <= 1'b0;
         busy      <= 1'b1;
         fail      <= 1'b0;
      end else begin
         pll_reset <= (state_d == ST_RESET_HOLD) ||
                      (state_d == ST_FAIL);
         pix_rst   <= (state_d != ST_RUN);
         locked    <= (state_d == ST_RUN);
         busy      <= (state_d == ST_RESET_HOLD) ||
                      (state_d == ST_WAIT_LOCK) ||
                      (state_d == ST_STABLE);
         fail      <= fail_d;
      end
   end

   // dividers load only on entry to reset hold, never while PLL runs
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_cur <= MODE_DEF;
         idsel    <= pll_dyn_enc(MODE_TABLE[MODE_DEF].idiv);
         fbdsel   <= pll_dyn_enc(MODE_TABLE[MODE_DEF].fbdiv);
         odsel    <= pll_dyn_enc(MODE_TABLE[MODE_DEF].odiv);
      end else if (load) begin
         mode_cur <= mode_nxt;
         idsel    <= pll_dyn_enc(mode_ent.idiv);
         fbdsel   <= pll_dyn_enc(mode_ent.fbdiv);
         odsel    <= pll_dyn_enc(mode_ent.odiv);
      end
   end

endmodule

// File: tb/tb_dvi_pll_ctrl.sv
// tb_dvi_pll_ctrl: directed bench for dvi_pll_ctrl with a timestamp-based
// reference model compared every cycle plus literal timing expectations.
`timescale 1ns/1ps
module tb_dvi_pll_ctrl;

   localparam int RST_C = 4;
   localparam int LT    = 64;
   localparam int SC    = 8;
   localparam int MR    = 3;

`ifdef DVI_PLL_CTRL_DYN_EN
   localparam bit DYN = 1'b1;
`else
   localparam bit DYN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] mode_sel = 2'd0;
   logic       mode_req = 1'b0;
   logic       pll_lock = 1'b0;
   logic       pll_reset;
   logic [5:0] idsel;
   logic [5:0] fbdsel;
   logic [5:0] odsel;
   logic       pix_rst;
   logic       locked;
   logic       busy;
   logic       fail;
   logic [1:0] mode_cur;

   dvi_pll_ctrl #(
      .RST_CYCLES    (RST_C),
      .LOCK_TIMEOUT  (LT),
      .STABLE_CYCLES (SC),
      .MAX_RETRY     (MR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mode_sel  (mode_sel),
      .mode_req  (mode_req),
      .pll_lock  (pll_lock),
      .pll_reset (pll_reset),
      .idsel     (idsel),
      .fbdsel    (fbdsel),
      .odsel     (odsel),
      .pix_rst   (pix_rst),
      .locked    (locked),
      .busy      (busy),
      .fail      (fail),
      .mode_cur  (mode_cur)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int idv [4] = '{4, 3, 0, 2};
   int fbv [4] = '{36, 54, 4, 13};
   int odv [4] = '{4, 2, 4, 4};

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // model phases: 0 hold, 1 wait, 2 stable, 3 run, 4 fail
   int ph;
   int t_ent;
   int t_w;
   int t_l;
   int m_retry;
   int m_mode;
   bit m_fail;
   bit m_s1;
   bit m_ls;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         ph = 0; t_ent = cyc; t_w = 0; t_l = 0;
         m_retry = 0; m_mode = 0; m_fail = 0; m_s1 = 0; m_ls = 0;
      end else begin
         case (ph)
            0: if (cyc - t_ent == RST_C) begin ph = 1; t_w = cyc; end
            1: begin
               if (m_ls) ph = 2;
               else if (cyc - t_w == LT) begin
                  m_retry++;
                  if (m_retry == MR) begin ph = 4; m_fail = 1; end
                  else begin ph = 0; t_ent = cyc; end
               end
            end
            2: begin
               if (!m_ls) begin ph = 1; t_w = cyc; end
               else if (cyc - ((t_l > t_w) ? t_l : t_w) == SC) begin
                  ph = 3; m_retry = 0;
               end
            end
            3: begin
               if (DYN && mode_req) begin
                  ph = 0; t_ent = cyc; m_mode = mode_sel;
               end else if (!m_ls) begin
                  ph = 0; t_ent = cyc;
               end
            end
            4: begin
               if (mode_req) begin
                  ph = 0; t_ent = cyc; m_retry = 0; m_fail = 0;
                  if (DYN) m_mode = mode_sel;
               end
            end
            default: ph = 0;
         endcase
         if (!m_ls && m_s1) t_l = cyc;
         m_ls = m_s1;
         m_s1 = pll_lock;
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("pll_reset", pll_reset, (ph == 0 || ph == 4) ? 1 : 0);
         chk("pix_rst", pix_rst, (ph != 3) ? 1 : 0);
         chk("locked", locked, (ph == 3) ? 1 : 0);
         chk("busy", busy, (ph <= 2) ? 1 : 0);
         chk("fail", fail, m_fail ? 1 : 0);
         chk("mode_cur", mode_cur, m_mode);
         chk("idsel", idsel, 63 - idv[m_mode]);
         chk("fbdsel", fbdsel, 63 - fbv[m_mode]);
         chk("odsel", odsel, 63 - odv[m_mode]);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic sig(input int which);
      case (which)
         0: return pll_reset;
         1: return pix_rst;
         2: return locked;
         default: return fail;
      endcase
   endfunction

   task automatic wait_sig(input int which, input logic val,
                           input int lim, input string nm);
      int found = 0;
      for (int i = 0; i < lim; i++) begin
         if (sig(which) === val) begin
            found = 1;
            break;
         end
         tick(1);
      end
      chk({"wait_", nm}, found, 1);
   endtask

   initial begin
      int r;
      int t;
      int w;
      tick(3);
      rst = 1'b0;
      r = cyc;

      // power-up: lock 20 cycles after pll_reset falls
      wait_sig(0, 1'b0, 50, "pwr_rst_fall");
      chk("pwr_rst_fall_cyc", cyc, r + 4);
      w = cyc;
      tick(20);
      pll_lock = 1'b1;
      t = cyc;
      chk("pwr_lock_at", t, w + 20);
      wait_sig(1, 1'b0, 100, "pwr_release");
      chk("pwr_release_cyc", cyc, t + 10);
      chk("pwr_locked", locked, 1);

      // lock loss in RUN, then a one-cycle glitch during STABLE
      tick(3);
      pll_lock = 1'b0;
      t = cyc;
      wait_sig(1, 1'b1, 20, "drop_pix_rst");
      chk("drop_pix_rst_cyc", cyc, t + 3);
      chk("drop_pll_reset", pll_reset, 1);
      chk("drop_locked", locked, 0);
      tick(1);
      pll_lock = 1'b1;
      wait_sig(0, 1'b0, 20, "glitch_wl");
      tick(2);
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      t = cyc;
      wait_sig(1, 1'b0, 100, "glitch_release");
      chk("glitch_release_cyc", cyc, t + 10);

      // mode change request in RUN, second request while holding
      tick(2);
      mode_sel = 2'd1;
      mode_req = 1'b1;
      tick(1);
      mode_req = 1'b0;
      chk("mc_pll_reset", pll_reset, DYN ? 1 : 0);
      chk("mc_pix_rst", pix_rst, DYN ? 1 : 0);
      chk("mc_locked", locked, DYN ? 0 : 1);
      chk("mc_mode_cur", mode_cur, DYN ? 1 : 0);
      chk("mc_idsel", idsel, DYN ? 60 : 59);
      chk("mc_fbdsel", fbdsel, DYN ? 9 : 27);
      chk("mc_odsel", odsel, DYN ? 61 : 59);
      tick(1);
      mode_sel = 2'd3;
      mode_req = 1'b1;
      tick(1);
      mode_req = 1'b0;
      tick(1);
      chk("mc_ignored_mode", mode_cur, DYN ? 1 : 0);
      chk("mc_ignored_fbdsel", fbdsel, DYN ? 9 : 27);
      wait_sig(2, 1'b1, 100, "mc_relock");

      // reset in the middle of WAIT_LOCK
      pll_lock = 1'b0;
      wait_sig(0, 1'b1, 20, "rw_hold");
      wait_sig(0, 1'b0, 20, "rw_wait");
      tick(10);
      rst = 1'b1;
      tick(1);
      chk("rst_pll_reset", pll_reset, 1);
      chk("rst_pix_rst", pix_rst, 1);
      chk("rst_busy", busy, 1);
      chk("rst_locked", locked, 0);
      chk("rst_fail", fail, 0);
      chk("rst_mode_cur", mode_cur, 0);
      chk("rst_idsel", idsel, 59);
      chk("rst_fbdsel", fbdsel, 27);
      chk("rst_odsel", odsel, 59);
      tick(2);
      rst = 1'b0;
      r = cyc;

      // no lock: three timeouts then sticky fail
      wait_sig(3, 1'b1, 400, "fail_set");
      chk("fail_cyc", cyc, r + 204);
      chk("fail_pll_reset", pll_reset, 1);
      chk("fail_pix_rst", pix_rst, 1);
      tick(5);
      chk("fail_sticky", fail, 1);
      mode_sel = 2'd2;
      mode_req = 1'b1;
      tick(1);
      mode_req = 1'b0;
      chk("rec_fail", fail, 0);
      chk("rec_pll_reset", pll_reset, 1);
      chk("rec_mode_cur", mode_cur, DYN ? 2 : 0);
      chk("rec_idsel", idsel, DYN ? 63 : 59);
      chk("rec_fbdsel", fbdsel, DYN ? 59 : 27);
      chk("rec_odsel", odsel, 59);
      pll_lock = 1'b1;
      wait_sig(2, 1'b1, 100, "rec_locked");
      tick(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
